demux_serializer: RTL

- Input-side counterpart of the output mux in the decryption datapath.
- Accepts wide words from the upstream interface and routes each one to one of three decryption channels, selected per word.
- Serializes each word into byte-sized outputs, one per clock, MSB first, on the chosen channel's data/valid pair.
- Sits between the input interface and the three decryptor blocks. Their results are recombined downstream by the output mux.

---
 rtl/demux_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/demux_serializer.sv
// ============================================================================
// Module      : demux_serializer
// Description : Routes each wide input word to one of three channels and
//               serializes it MSB-first, one SYS_DWIDTH byte per clock.
//               Optional macro DEMUX_BACK_TO_BACK_EN removes the idle cycle
//               between consecutive words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_serializer #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            select,
    input  logic [MST_DWIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [SYS_DWIDTH-1:0] data0_o,
    output logic [SYS_DWIDTH-1:0] data1_o,
    output logic [SYS_DWIDTH-1:0] data2_o,
    output logic                  valid0_o,
    output logic                  valid1_o,
    output logic                  valid2_o,
    output logic                  err_o
);

    localparam int N  = MST_DWIDTH / SYS_DWIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_last = CW'(N - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);
    localparam logic [1:0]    c_sel_invalid = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [MST_DWIDTH-1:0]   r_word;
    logic [1:0]              r_sel;
    logic [SYS_DWIDTH-1:0]   w_byte;
    logic                    w_load_ok;

    assign w_byte = r_word[MST_DWIDTH-1 -: SYS_DWIDTH];

`ifdef DEMUX_BACK_TO_BACK_EN
    assign ready_o = (r_state == IDLE) || ((r_state == SHIFT) && (r_cnt == c_last));
`else
    assign ready_o = (r_state == IDLE);
`endif

    assign w_load_ok = valid_i && ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_word   <= '0;
            r_sel    <= 2'b00;
            data0_o  <= '0;
            data1_o  <= '0;
            data2_o  <= '0;
            valid0_o <= 1'b0;
            valid1_o <= 1'b0;
            valid2_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            // Outputs are zero unless a byte is emitted on this edge
            data0_o  <= '0;
            data1_o  <= '0;
            data2_o  <= '0;
            valid0_o <= 1'b0;
            valid1_o <= 1'b0;
            valid2_o <= 1'b0;
            err_o    <= 1'b0;

            if (r_state == SHIFT) begin
                case (r_sel)
                    2'b00:   begin data0_o <= w_byte; valid0_o <= 1'b1; end
                    2'b01:   begin data1_o <= w_byte; valid1_o <= 1'b1; end
                    2'b10:   begin data2_o <= w_byte; valid2_o <= 1'b1; end
                    default: ;
                endcase
                r_word <= r_word << SYS_DWIDTH;
                if (r_cnt == c_last) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_one;
                end
            end

            // A word loaded here overrides the shift/return-to-idle above
            if (w_load_ok) begin
                if (select == c_sel_invalid) begin
                    err_o   <= 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_word  <= data_i;
                    r_sel   <= select;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
            end
        end
    end

endmodule

`default_nettype wire
